// File: rtl/count_binary_button_pkg.sv
// Shared types and constants for the button-edge PIO controller.
// Macro COUNT_BINARY_BUTTON_TIMESTAMP_EN widens event entries with a 16-bit cycle stamp.
package count_binary_button_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_CLR,
        ST_PUSH
    } state_e;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    localparam int unsigned BTN_W = 4;
    localparam int unsigned TS_W  = 16;

`ifdef COUNT_BINARY_BUTTON_TIMESTAMP_EN
    localparam int unsigned EVT_W = BTN_W + TS_W;
`else
    localparam int unsigned EVT_W = BTN_W;
`endif

endpackage

// File: rtl/count_binary_button_fifo.sv
// First-word fall-through synchronous FIFO; DEPTH must be a power of two.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module count_binary_button_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Extra MSB on each pointer separates full (MSBs differ) from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/count_binary_button_ctrl.sv
// Polls/serves a button PIO edge-capture register and queues non-zero captures.
// Macro COUNT_BINARY_BUTTON_TIMESTAMP_EN appends a 16-bit cycle stamp to each event.
module count_binary_button_ctrl
    import count_binary_button_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned POLL_CYCLES = 1000,
    parameter logic [3:0]  IRQ_MASK    = 4'hF
) (
    input  logic             clk,
    input  logic             reset,
    output logic [1:0]       pio_address,
    output logic             pio_chipselect,
    output logic             pio_write_n,
    output logic [31:0]      pio_writedata,
    input  logic [31:0]      pio_readdata,
    input  logic             pio_irq,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [EVT_W-1:0] evt_data,
    output logic             overflow,
    input  logic             ovf_clr
);
    localparam int unsigned    PW        = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [PW-1:0]  POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam bit             POLL_EN   = (POLL_CYCLES != 0);

    state_e           state_q, state_d;
    logic [PW-1:0]    poll_q, poll_d;
    logic [BTN_W-1:0] cap_q, cap_d;
    logic             ovf_q, ovf_d;
    logic             push_req, pop, drop;
    logic             fifo_empty, fifo_full;
    logic [EVT_W-1:0] entry;
    logic             unused_readdata_hi;

    assign unused_readdata_hi = ^pio_readdata[31:BTN_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            poll_q  <= '0;
            cap_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            poll_q  <= poll_d;
            cap_q   <= cap_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        poll_d         = '0;
        cap_d          = cap_q;
        push_req       = 1'b0;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_address    = PIO_ADDR_DATA;
        pio_writedata  = '0;
        unique case (state_q)
            ST_INIT: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = PIO_ADDR_MASK;
                pio_writedata  = {28'b0, IRQ_MASK};
                state_d        = ST_IDLE;
            end
            ST_IDLE: begin
                if (pio_irq || (POLL_EN && poll_q == POLL_LAST)) state_d = ST_RD_REQ;
                else                                             poll_d  = poll_q + PW'(1);
            end
            ST_RD_REQ: begin
                pio_chipselect = 1'b1;
                pio_address    = PIO_ADDR_EDGE;
                state_d        = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                cap_d   = pio_readdata[BTN_W-1:0];
                state_d = ST_CLR;
            end
            ST_CLR: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = PIO_ADDR_EDGE;
                state_d        = ST_PUSH;
            end
            ST_PUSH: begin
                push_req = (cap_q != '0);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
        // State resets to INIT, but the bus must stay quiet while reset is held.
        if (reset) begin
            pio_chipselect = 1'b0;
            pio_write_n    = 1'b1;
            pio_address    = PIO_ADDR_DATA;
            pio_writedata  = '0;
        end
    end

    assign evt_valid = ~fifo_empty;
    assign pop       = evt_valid & evt_ready;
    assign drop      = push_req & fifo_full & ~pop;
    assign ovf_d     = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    assign overflow  = ovf_q;

`ifdef COUNT_BINARY_BUTTON_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q, ts_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + TS_W'(1);
            if (state_q == ST_RD_WAIT) ts_q <= ts_cnt_q;
        end
    end

    assign entry = {ts_q, cap_q};
`else
    assign entry = cap_q;
`endif

    count_binary_button_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push_req),
        .data_i  (entry),
        .pop_i   (pop),
        .data_o  (evt_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

endmodule

// File: tb/tb_count_binary_button_ctrl.sv
// Randomized bench: PIO slave model plus an event scoreboard for the button controller.
module tb_count_binary_button_ctrl;
    import count_binary_button_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned POLL  = 8;
    localparam logic [3:0]  MASK  = 4'hF;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       pio_address;
    logic             pio_chipselect, pio_write_n;
    logic [31:0]      pio_writedata;
    logic [31:0]      pio_readdata = '0;
    logic             pio_irq = 1'b0;
    logic             evt_valid;
    logic             evt_ready = 1'b0;
    logic [EVT_W-1:0] evt_data;
    logic             overflow;
    logic             ovf_clr = 1'b0;

    always #5 clk = ~clk;

    count_binary_button_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .POLL_CYCLES (POLL),
        .IRQ_MASK    (MASK)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .pio_irq        (pio_irq),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_data       (evt_data),
        .overflow       (overflow),
        .ovf_clr        (ovf_clr)
    );

    int unsigned      n_tests = 0;
    int unsigned      n_fail  = 0;
    logic [3:0]       edge_reg = '0;
    logic [3:0]       mask_reg = '0;
    logic [3:0]       inject   = '0;
    logic [EVT_W-1:0] q_m [$];
    logic             ovf_m = 1'b0;
    int unsigned      cd = 0;
    logic [EVT_W-1:0] pend = '0;
    int unsigned      cyc = 0;
    bit               poll_phase = 1'b0;
    int unsigned      n_rd = 0;
    int unsigned      last_rd = 0;
    int unsigned      ev_rd_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit bus_reading();
        return pio_chipselect && pio_write_n && (pio_address == PIO_ADDR_EDGE);
    endfunction

    // One clock: check outputs, advance the reference model across the edge, drive the slave.
    task automatic step();
        logic        rd_edge, wr_edge, wr_mask, pop_m, push_now, drop_m;
        logic [31:0] rd_next;
        check_eq("evt_valid", 32'(evt_valid), 32'(q_m.size() != 0));
        if (q_m.size() != 0) check_eq("evt_data", 32'(evt_data), 32'(q_m[0]));
        check_eq("overflow", 32'(overflow), 32'(ovf_m));
        if (!pio_chipselect) check_eq("idle_addr", 32'(pio_address), 32'd0);
        rd_edge = bus_reading();
        wr_edge = pio_chipselect && !pio_write_n && (pio_address == PIO_ADDR_EDGE);
        wr_mask = pio_chipselect && !pio_write_n && (pio_address == PIO_ADDR_MASK);
        if (wr_edge) check_eq("clr_data", pio_writedata, 32'd0);
        if (wr_mask) check_eq("mask_data", pio_writedata, {28'b0, MASK});
        if (rd_edge && poll_phase) begin
            if (n_rd > 0) check_eq("poll_period", 32'(cyc - last_rd), 32'(POLL + 4));
            n_rd++;
            last_rd = cyc;
        end

        push_now = 1'b0;
        if (cd != 0) begin
            cd--;
            push_now = (cd == 0);
        end
        if (rd_edge) begin
            cd = 3;
            if (edge_reg != 0) ev_rd_cyc = cyc;
`ifdef COUNT_BINARY_BUTTON_TIMESTAMP_EN
            pend = {16'(cyc + 1), edge_reg};
`else
            pend = edge_reg;
`endif
        end

        pop_m  = (q_m.size() != 0) && evt_ready;
        drop_m = 1'b0;
        if (pop_m) void'(q_m.pop_front());
        if (push_now && pend[3:0] != 0) begin
            if (q_m.size() < DEPTH) q_m.push_back(pend);
            else                    drop_m = 1'b1;
        end
        if (drop_m)       ovf_m = 1'b1;
        else if (ovf_clr) ovf_m = 1'b0;

        rd_next = rd_edge ? {28'b0, edge_reg} : 32'd0;
        if (wr_edge) edge_reg = '0;
        if (wr_mask) mask_reg = pio_writedata[3:0];
        edge_reg = edge_reg | inject;

        @(posedge clk);
        #1;
        pio_readdata = rd_next;
        pio_irq      = |(edge_reg & mask_reg);
        cyc++;
        @(negedge clk);
        inject = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_eq("rst_cs", 32'(pio_chipselect), 32'd0);
        check_eq("rst_write_n", 32'(pio_write_n), 32'd1);
        check_eq("rst_addr", 32'(pio_address), 32'd0);
        check_eq("rst_wdata", pio_writedata, 32'd0);
        check_eq("rst_valid", 32'(evt_valid), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        q_m.delete();
        ovf_m = 1'b0; cd = 0; edge_reg = '0; mask_reg = '0; inject = '0;
        pio_readdata = '0; pio_irq = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        cyc = 0;
        check_eq("init_cs", 32'(pio_chipselect), 32'd1);
        check_eq("init_write_n", 32'(pio_write_n), 32'd0);
        check_eq("init_addr", 32'(pio_address), 32'(PIO_ADDR_MASK));
        check_eq("init_wdata", pio_writedata, 32'h0000_000F);
    endtask

    // Inject only when no edge-register read is in flight, so the event cannot be cleared unseen.
    task automatic inject_evt(input logic [3:0] v);
        int unsigned n = 0;
        while ((cd != 0 || bus_reading()) && n < 20) begin
            step();
            n++;
        end
        check_eq("inject_window", 32'(n < 20), 32'd1);
        inject = v;
        step();
    endtask

    task automatic count_pops(input int unsigned len, output int unsigned cnt);
        cnt = 0;
        evt_ready = 1'b1;
        repeat (len) begin
            if (evt_valid) cnt++;
            step();
        end
        evt_ready = 1'b0;
    endtask

    initial begin
        int unsigned cnt;
        @(negedge clk);
        do_reset();

        // Idle polling with no edges: fixed read cadence, nothing queued.
        poll_phase = 1'b1;
        evt_ready  = 1'b1;
        repeat (70) step();
        poll_phase = 1'b0;
        check_eq("poll_reads", 32'(n_rd >= 5), 32'd1);

        // Single irq event with edge pattern 0101.
        evt_ready = 1'b0;
        inject_evt(4'b0101);
        repeat (10) step();
        check_eq("evt5_valid", 32'(evt_valid), 32'd1);
        check_eq("evt5_data", 32'(evt_data[3:0]), 32'h5);
        count_pops(4, cnt);
        check_eq("evt5_pops", cnt, 32'd1);

        // Five events into a depth-4 FIFO; clear lands on the drop cycle and must lose.
        for (int unsigned i = 0; i < 5; i++) begin
            inject = '0;
            inject_evt(4'(i + 1));
            repeat (12) begin
                ovf_clr = (i == 4) && (cd == 1);
                step();
            end
            ovf_clr = 1'b0;
        end
        check_eq("ovf_set", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check_eq("ovf_cleared", 32'(overflow), 32'd0);
        count_pops(8, cnt);
        check_eq("held_entries", cnt, 32'd4);

        // Full FIFO with a pop in the push cycle: nothing dropped.
        do_reset();
        for (int unsigned i = 0; i < 4; i++) begin
            inject_evt(4'(8 + i));
            repeat (12) step();
        end
        inject_evt(4'hC);
        repeat (12) begin
            evt_ready = (cd == 1);
            step();
        end
        evt_ready = 1'b0;
        check_eq("full_pop_ovf", 32'(overflow), 32'd0);
        count_pops(8, cnt);
        check_eq("full_pop_entries", cnt, 32'd4);

        // Reset during PUSH discards the pending entry.
        inject_evt(4'hA);
        cnt = 0;
        while (cd != 1 && cnt < 20) begin
            step();
            cnt++;
        end
        check_eq("reach_push", 32'(cd == 1), 32'd1);
        do_reset();
        repeat (15) step();
        check_eq("mid_rst_empty", 32'(evt_valid), 32'd0);

`ifdef COUNT_BINARY_BUTTON_TIMESTAMP_EN
        begin
            int unsigned r0, r1;
            logic [15:0] d0, d1;
            do_reset();
            inject_evt(4'h1);
            repeat (12) step();
            r0 = ev_rd_cyc;
            repeat (88) step();
            inject_evt(4'h2);
            repeat (12) step();
            r1 = ev_rd_cyc;
            d0 = evt_data[19:4];
            evt_ready = 1'b1;
            step();
            evt_ready = 1'b0;
            d1 = evt_data[19:4];
            check_eq("ts_delta", 32'(d1 - d0), 32'(r1 - r0));
        end
`endif

        // Randomized traffic: sparse edges, varying consumer pressure, occasional clears.
        do_reset();
        for (int unsigned i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) inject = 4'($urandom_range(1, 15));
            evt_ready = (i < 700) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0);
            ovf_clr   = ($urandom_range(0, 19) == 0);
            step();
        end
        ovf_clr = 1'b0;
        evt_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/count_binary_button_ctrl.md
COUNT_BINARY_BUTTON_CTRL -- requirements
Module: count_binary_button_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, 4, event FIFO entries (power of two, 2..16) SHALL be supported.
REQ-002 Parameter POLL_CYCLES, 1000, the idle cycles between forced polls when no irq arrives SHALL be configurable (0 disables polling).
REQ-003 Parameter IRQ_MASK, 4'hF, the value written to the PIO interrupt-mask register at init SHALL be configurable.
REQ-004 clk  in  1  single clock for the block.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pio_address  out  2  PIO register address.
REQ-007 pio_chipselect  out  1  PIO select.
REQ-008 pio_write_n  out  1  active-low PIO write.
REQ-009 pio_writedata  out  32  PIO write data.
REQ-010 pio_readdata  in  32  PIO read data, registered; valid one cycle after the address is presented.
REQ-011 pio_irq  in  1  PIO interrupt (edge_capture & mask).
REQ-012 evt_valid / evt_ready  out / in  1 / 1  event stream handshake.
REQ-013 evt_data  out  4 (20 with timestamp)  captured button-edge bits, plus the timestamp in [19:4] when enabled.
REQ-014 overflow  out  1  sticky event-drop flag; ovf_clr  in  1  clears it.

Function
REQ-015 FSM states: INIT, IDLE, RD_REQ, RD_WAIT, CLR, PUSH; INIT SHALL be entered from reset.
REQ-016 INIT: one cycle with chipselect=1, write_n=0, address=2, writedata=IRQ_MASK; then go to IDLE.
REQ-017 IDLE: chipselect=0, write_n=1; go to RD_REQ when pio_irq=1, or when the poll counter reaches POLL_CYCLES-1.
REQ-018 The poll counter SHALL increment in IDLE only and reset to 0 on leaving IDLE.
REQ-019 RD_REQ: chipselect=1, write_n=1, address=3; go to RD_WAIT.
REQ-020 RD_WAIT: capture pio_readdata[3:0] into cap_reg; go to CLR.
REQ-021 CLR: chipselect=1, write_n=0, address=3, writedata=0; go to PUSH.
REQ-022 PUSH: if cap_reg is nonzero and the FIFO is not full, write the entry; if cap_reg is nonzero and the FIFO is full, drop the entry and set overflow; if cap_reg is zero, write nothing; in all three cases go to IDLE.
REQ-023 Edges arriving between RD_REQ and CLR are cleared by the CLR write and SHALL be lost by design; bench SHALL not flag this.
REQ-024 Output bus SHALL never assert write and read in the same cycle; pio_address SHALL hold 0 when chipselect=0.
REQ-025 FIFO: evt_valid=!empty; pop on evt_valid&evt_ready; first-word fall-through (evt_data is valid while evt_valid=1).
REQ-026 A simultaneous push and pop when full SHALL be accepted: the pop frees the slot and the entry is not dropped.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH, with an extra bit used to distinguish full from empty.
REQ-028 overflow: set wins over ovf_clr in the same cycle.

Reset
REQ-029 On reset assertion, at any state: FSM=INIT, chipselect=0, write_n=1, address=0, writedata=0, FIFO empty (evt_valid=0), overflow=0, cap_reg=0, poll counter=0, timestamp=0.
REQ-030 Reset mid-transaction SHALL abandon the cycle; the pending FIFO entry is discarded.

Configuration
REQ-031 Macro COUNT_BINARY_BUTTON_TIMESTAMP_EN defined: a 16-bit free-running cycle counter (wraps at 16'hFFFF to 0) SHALL be sampled in RD_WAIT and stored with the entry; evt_data is 20 bits.
REQ-032 Macro undefined: no counter; evt_data is 4 bits.

Structure
REQ-033 Package count_binary_button_pkg: FSM state enum; PIO address constants (DATA=0, MASK=2, EDGE=3); the timestamp width constant.
REQ-034 Sub-module count_binary_button_fifo: the parameterized sync FIFO; the controller instantiates it once.

Verification
REQ-035 Release reset -> first bus cycle is a write to address 2 with data 32'h0000000F; the FSM then sits in IDLE.
REQ-036 Slave returns edge 4'b0101 with irq=1 -> read address 3, the next cycle captures, then write address 3 -> evt_data=4'h5, evt_valid=1.
REQ-037 POLL_CYCLES=8, irq=0, edge 0 -> poll read every 8 IDLE cycles; no FIFO push occurs.
REQ-038 evt_ready=0 with 5 irq events and FIFO_DEPTH=4 -> 4 entries held, the 5th dropped, overflow=1; ovf_clr -> overflow=0.
REQ-039 FIFO full, evt_ready=1 in the PUSH cycle -> no drop; overflow stays 0.
REQ-040 With TIMESTAMP_EN: two events 100 cycles apart -> evt_data[19:4] differ by 100.
